// File: rtl/sync_s2p_word_collector_sha3.sv
// LSB-first serial-to-parallel word collector for the SHA3 datapath: shifts in
// `width` bits, then holds the word on a valid/ready handshake with busy and error flags.
module sync_s2p_word_collector_sha3 #(
  parameter int width = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             data_valid,
  output logic             ki_b,
  output logic [width-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  input  logic             err_clr,
  output logic             frame_err,
  output logic             overrun_err
);

  localparam int CW = $clog2(width) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [width-1:0] sr_reg;
  logic [width-1:0] sr_shift;
  logic             frame_set;
  logic             overrun_set;

  // New bit enters at the top so the first bit of a burst ends up in bit 0.
  genvar gi;
  generate
    for (gi = 0; gi < width; gi++) begin : g_shift
      if (gi == width - 1) begin : g_top
        assign sr_shift[gi] = data_in;
      end else begin : g_body
        assign sr_shift[gi] = sr_reg[gi+1];
      end
    end
  endgenerate

  assign frame_set   = (state_reg == SHIFT) && !data_valid;
  assign overrun_set = (state_reg == HOLD) && data_valid && !word_ready;
  assign word_out    = sr_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sr_reg      <= '0;
      ki_b        <= 1'b0;
      word_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      // Sticky flags: a new error in the clear cycle wins over the clear.
      frame_err   <= frame_set | (frame_err & ~err_clr);
      overrun_err <= overrun_set | (overrun_err & ~err_clr);

      case (state_reg)
        IDLE: begin
          if (data_valid) begin
            sr_reg    <= sr_shift;
            cnt_reg   <= CW'(1);
            state_reg <= SHIFT;
            ki_b      <= 1'b1;
          end
        end

        SHIFT: begin
          if (data_valid) begin
            sr_reg <= sr_shift;
            if (cnt_reg == LAST_BIT) begin
              cnt_reg    <= '0;
              state_reg  <= HOLD;
              word_valid <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end else begin
            // Short burst: partial contents stay in sr but are never presented.
            cnt_reg   <= '0;
            state_reg <= IDLE;
            ki_b      <= 1'b0;
          end
        end

        HOLD: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            if (data_valid) begin
              sr_reg    <= sr_shift;
              cnt_reg   <= CW'(1);
              state_reg <= SHIFT;
            end else begin
              state_reg <= IDLE;
              ki_b      <= 1'b0;
            end
          end
        end

        default: begin
          state_reg  <= IDLE;
          cnt_reg    <= '0;
          ki_b       <= 1'b0;
          word_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_s2p_word_collector_sha3.sv
// Directed bench: an 8-bit collector for the hand-computed cases and a
// 512-bit collector streamed against a bench-held copy of each word.
module tb_sync_s2p_word_collector_sha3;

  logic clk;
  logic reset;

  logic       d8_in, d8_valid, d8_ready, d8_clr;
  logic       d8_ki_b, d8_wv, d8_ferr, d8_oerr;
  logic [7:0] d8_out;

  logic         d5_in, d5_valid, d5_ready, d5_clr;
  logic         d5_ki_b, d5_wv, d5_ferr, d5_oerr;
  logic [511:0] d5_out;

  int errors = 0;
  int checks = 0;

  sync_s2p_word_collector_sha3 #(.width(8)) dut8 (
    .clk(clk), .reset(reset), .data_in(d8_in), .data_valid(d8_valid),
    .ki_b(d8_ki_b), .word_out(d8_out), .word_valid(d8_wv),
    .word_ready(d8_ready), .err_clr(d8_clr),
    .frame_err(d8_ferr), .overrun_err(d8_oerr)
  );

  sync_s2p_word_collector_sha3 dut512 (
    .clk(clk), .reset(reset), .data_in(d5_in), .data_valid(d5_valid),
    .ki_b(d5_ki_b), .word_out(d5_out), .word_valid(d5_wv),
    .word_ready(d5_ready), .err_clr(d5_clr),
    .frame_err(d5_ferr), .overrun_err(d5_oerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drives n bits of v, LSB first; optionally checks busy and word_valid per edge.
  task automatic send8(input logic [7:0] v, input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      d8_in    = v[i];
      d8_valid = 1'b1;
      @(posedge clk); #1;
      if (chk) begin
        check("ki_b_busy", d8_ki_b, 1);
        check("wv_collect", d8_wv, (i == 7));
      end
    end
  endtask

  task automatic edge8;
    @(posedge clk); #1;
  endtask

  logic [511:0] wexp;
  int           gap;
  bit           accepted;

  initial begin
    reset = 1'b0;
    d8_in = 0; d8_valid = 0; d8_ready = 0; d8_clr = 0;
    d5_in = 0; d5_valid = 0; d5_ready = 0; d5_clr = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ki_b", d8_ki_b, 0);
    check("rst_wv", d8_wv, 0);
    check("rst_out", d8_out, 0);
    check("rst_ferr", d8_ferr, 0);
    check("rst_oerr", d8_oerr, 0);
    reset = 1'b1;
    edge8();
    check("post_rst_idle", d8_ki_b, 0);

    // Basic: 1,0,1,1,0,0,1,0 -> 0x4D
    send8(8'h4D, 8, 1);
    check("basic_out", d8_out, 8'h4D);
    d8_valid = 0;
    edge8();
    check("basic_hold_wv", d8_wv, 1);
    check("basic_hold_ki_b", d8_ki_b, 1);
    d8_ready = 1;
    edge8();
    check("basic_acc_wv", d8_wv, 0);
    check("basic_acc_ki_b", d8_ki_b, 0);
    d8_ready = 0;

    // Back-to-back 0xA5 then 0x3C, ready held high
    d8_ready = 1;
    send8(8'hA5, 8, 1);
    check("b2b_first", d8_out, 8'hA5);
    send8(8'h3C, 8, 1);
    check("b2b_second", d8_out, 8'h3C);
    d8_valid = 0;
    edge8();
    check("b2b_done_wv", d8_wv, 0);
    check("b2b_ferr", d8_ferr, 0);
    check("b2b_oerr", d8_oerr, 0);
    d8_ready = 0;

    // Overrun: 0xFF burst while 0xA5 is held
    send8(8'hA5, 8, 1);
    send8(8'hFF, 8, 0);
    d8_valid = 0;
    check("ovr_out_kept", d8_out, 8'hA5);
    check("ovr_flag", d8_oerr, 1);
    check("ovr_wv", d8_wv, 1);
    check("ovr_no_ferr", d8_ferr, 0);
    d8_clr = 1;
    edge8();
    d8_clr = 0;
    check("ovr_cleared", d8_oerr, 0);
    d8_ready = 1;
    edge8();
    check("ovr_acc_wv", d8_wv, 0);
    d8_ready = 0;

    // Framing: burst of 5 bits, then a full 0x81
    send8(8'h1F, 5, 1);
    d8_valid = 0;
    edge8();
    check("frm_flag", d8_ferr, 1);
    check("frm_idle", d8_ki_b, 0);
    check("frm_wv", d8_wv, 0);
    send8(8'h81, 8, 1);
    check("frm_next_out", d8_out, 8'h81);
    d8_valid = 0;
    d8_ready = 1;
    d8_clr   = 1;
    edge8();
    d8_ready = 0;
    d8_clr   = 0;
    check("frm_cleared", d8_ferr, 0);

    // Reset between edges after 3 bits
    send8(8'h07, 3, 1);
    reset = 1'b0;
    #2;
    check("amid_ki_b", d8_ki_b, 0);
    check("amid_wv", d8_wv, 0);
    check("amid_out", d8_out, 0);
    d8_valid = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    send8(8'h5A, 8, 1);
    check("amid_next_out", d8_out, 8'h5A);
    check("amid_ferr", d8_ferr, 0);
    check("amid_oerr", d8_oerr, 0);
    d8_valid = 0;
    d8_ready = 1;
    edge8();
    d8_ready = 0;

    // Default width: random words, random ready, busy checked every cycle
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 16; j++) wexp[j*32 +: 32] = $urandom;
      gap = $urandom_range(0, 3);
      d5_valid = 0;
      d5_ready = 0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        check("w512_idle_ki_b", d5_ki_b, 0);
      end
      for (int i = 0; i < 512; i++) begin
        d5_in    = wexp[i];
        d5_valid = 1'b1;
        @(posedge clk); #1;
        if (i == 0 || i == 511) check("w512_busy_ki_b", d5_ki_b, 1);
        else if (d5_ki_b !== 1'b1) check("w512_busy_ki_b", d5_ki_b, 1);
      end
      d5_valid = 0;
      check("w512_valid", d5_wv, 1);
      accepted = 0;
      for (int t = 0; t < 16 && !accepted; t++) begin
        d5_ready = (t >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        check("w512_word", d5_out, wexp);
        accepted = d5_ready;
        @(posedge clk); #1;
        check("w512_ki_b", d5_ki_b, accepted ? 1'b0 : 1'b1);
      end
      d5_ready = 0;
      check("w512_errs", {d5_ferr, d5_oerr}, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_s2p_word_collector_sha3.md
# sync_s2p_word_collector_sha3

Synchronous serial-to-parallel collector that sits directly downstream of the MTD3L-to-sync parallel-to-serial stage of the SHA3 datapath. It samples the LSB-first serial bitstream delivered as one bit per `clk` while `data_valid` is high, reassembles a `width`-bit word, and presents it on a valid/ready handshake to the synchronous consumer. It returns an active-low busy indication (`ki_b`) to the serializer and flags framing and overrun errors.

## Interface
- `width`, 512: bits per word (serial burst length); legal range 2..4096.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted); one clock; reset is asynchronous and active-low.
- `data_in`  input  1  serial data bit from the upstream serializer, LSB of the word first.
- `data_valid`  input  1  `data_in` is a valid bit this cycle; held high for exactly `width` consecutive cycles per word.
- `ki_b`  output  1  active-low ready to upstream: 0 = idle and empty, 1 = collecting or holding a word.
- `word_out`  output  `width`  assembled word; bit 0 = first serial bit received.
- `word_valid`  output  1  `word_out` is complete and stable.
- `word_ready`  input  1  consumer accepts `word_out` on a cycle with `word_valid`=1.
- `err_clr`  input  1  synchronous clear of sticky error flags.
- `frame_err`  output  1  sticky: burst ended early (`data_valid` fell with 0 < count < `width`).
- `overrun_err`  output  1  sticky: bit arrived while a word was held and not accepted.

## Operation
- Storage: `width`-bit shift register `sr`; on each accepted bit, `sr <= {data_in, sr[width-1:1]}`. After `width` bits, first bit sits at `sr[0]`. `word_out` = `sr` (no separate copy).
- Bit counter `cnt`, $clog2(width)+1 bits, counts accepted bits of current word, 0..width-1.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE: `ki_b`=0, `word_valid`=0. `data_valid`=1 → shift bit, `cnt`=1, go SHIFT.
- SHIFT: `data_valid`=1 → shift bit, `cnt`+1; if this was bit `width`-1 (`cnt`==width-1) → go HOLD, `cnt`=0. `data_valid`=0 → set `frame_err`, `cnt`=0, go IDLE; `sr` contents left as-is, never presented.
- HOLD: `word_valid`=1, `sr` frozen. `word_ready`=1 and `data_valid`=0 → go IDLE. `word_ready`=1 and `data_valid`=1 (simultaneous) → word consumed AND bit shifted in as bit 0 of next word, `cnt`=1, go SHIFT. `word_ready`=0 and `data_valid`=1 → bit dropped, `sr` unchanged, set `overrun_err`, stay HOLD.
- `ki_b` = 1 in SHIFT and HOLD, 0 in IDLE; decoded from registered state (glitch-free).
- Errors: sticky until `err_clr`=1; if set and clear requested in same cycle, set wins.
- `word_ready` while `word_valid`=0 is ignored.

## Timing
- Reset (`reset`=0, async): state IDLE, `sr`=0, `cnt`=0, `word_out`=0, `word_valid`=0, `ki_b`=0, `frame_err`=0, `overrun_err`=0. Reset mid-burst or mid-HOLD discards the partial/held word with no error flagged.
- Reset deassertion is synchronous to upstream; first edge after release behaves as IDLE.
- Latency: last bit sampled at edge N → `word_valid`=1 and `word_out` final from edge N (visible cycle N+1).
- Throughput: one bit per cycle; back-to-back bursts with zero gap sustained provided `word_ready`=1 on the first cycle of `word_valid`.
- Handshake transfer completes on the rising edge where `word_valid`=1 and `word_ready`=1; `word_valid` drops after that edge unless the next word completes simultaneously (impossible for `width`≥2).
- `ki_b` rises the edge after the first bit sampled; falls the edge after acceptance when no new bit arrives.

## Test plan
- Basic: `width`=8, bits 1,0,1,1,0,0,1,0 on 8 consecutive valid cycles → `word_valid`=1 one cycle after last bit, `word_out`=0x4D; `ki_b`=1 from cycle 2 through HOLD; `word_ready`=1 → `word_valid`=0, `ki_b`=0 next cycle.
- Back-to-back: two bursts 0xA5 then 0x3C with no gap, `word_ready` tied 1 → two transfers 0xA5, 0x3C; no errors; state passes HOLD→SHIFT directly.
- Overrun: hold `word_ready`=0 after 0xA5, send burst 0xFF → `word_out` stays 0xA5, `overrun_err`=1; `err_clr` pulse → `overrun_err`=0.
- Framing: `width`=8, drop `data_valid` after 5 bits → `frame_err`=1, state IDLE, `word_valid` never asserts; following full burst 0x81 → `word_out`=0x81.
- Reset mid-burst: assert `reset`=0 after 3 bits (between edges) → all outputs 0 immediately; after release, full burst 0x5A → `word_out`=0x5A, no errors.
- Default `width`=512 random burst, `word_ready` random → every accepted word matches scoreboard, `ki_b` matches state decode every cycle.
